// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, combinational ROM address, IF/ID register.
// Next-PC selection priority: exception, redirect, interrupt, stall, PC+4.
// Optional build macro IF_ALIGN_CHECK_EN: misaligned redirects vector to EXC_VEC
// and pulse if_misalign for one cycle.
module if_fetch_stage #(
  parameter logic [31:0] RESET_VEC = 32'h80000000,
  parameter logic [31:0] IRQ_VEC   = 32'h80000004,
  parameter logic [31:0] EXC_VEC   = 32'h80000008,
  parameter logic [31:0] NOP_WORD  = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        exc_req,
  input  logic        irq,
  output logic        kernel,
`ifdef IF_ALIGN_CHECK_EN
  output logic        if_misalign,
`endif
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_trap,
  output logic [31:0] if_id_epc
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        irq_take;
  logic        redirect_bad;

  assign rom_addr = pc;
  assign kernel   = pc[31];

  // Kernel bit is sticky across sequential fetch; only the low 31 bits wrap.
  assign pc_plus4 = {pc[31], pc[30:0] + 31'd4};

  assign irq_take = irq & ~pc[31] & ~stall & ~redirect_valid & ~exc_req;

`ifdef IF_ALIGN_CHECK_EN
  assign redirect_bad = redirect_valid & (redirect_pc[1:0] != 2'b00);
`else
  assign redirect_bad = 1'b0;
`endif

  // PC and IF/ID pipeline register update in priority order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc             <= RESET_VEC;
      if_id_instr    <= NOP_WORD;
      if_id_pc_plus4 <= '0;
      if_id_trap     <= 1'b0;
      if_id_epc      <= '0;
    end else if (exc_req || redirect_bad) begin
      pc             <= EXC_VEC;
      if_id_instr    <= NOP_WORD;
      if_id_pc_plus4 <= '0;
      if_id_trap     <= 1'b0;
    end else if (redirect_valid) begin
      pc             <= redirect_pc;
      if_id_instr    <= NOP_WORD;
      if_id_pc_plus4 <= '0;
      if_id_trap     <= 1'b0;
    end else if (irq_take) begin
      // The squashed word at pc is re-fetched when the handler returns to epc.
      pc             <= IRQ_VEC;
      if_id_instr    <= NOP_WORD;
      if_id_pc_plus4 <= '0;
      if_id_trap     <= 1'b1;
      if_id_epc      <= pc;
    end else if (!stall) begin
      pc             <= pc_plus4;
      if_id_instr    <= rom_data;
      if_id_pc_plus4 <= pc_plus4;
      if_id_trap     <= 1'b0;
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  // One-cycle pulse for a misaligned redirect that was turned into an exception.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_misalign <= 1'b0;
    end else begin
      if_misalign <= redirect_bad & ~exc_req;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage with a behavioural ROM.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        exc_req;
  logic        irq;
  logic        kernel;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_trap;
  logic [31:0] if_id_epc;
`ifdef IF_ALIGN_CHECK_EN
  logic        if_misalign;
`endif

  int checks = 0;
  int fails  = 0;

  if_fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exc_req        (exc_req),
    .irq            (irq),
    .kernel         (kernel),
`ifdef IF_ALIGN_CHECK_EN
    .if_misalign    (if_misalign),
`endif
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_trap     (if_id_trap),
    .if_id_epc      (if_id_epc)
  );

  always #5 clk = ~clk;

  // ROM contents: word 0 of the kernel vector area is a fixed jump, others are address-derived.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h80000000) return 32'h08000003;
    return {a[15:0], ~a[31:16]};
  endfunction

  always_comb rom_data = rom_word(rom_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    exc_req = 1'b0; irq = 1'b0;
    step(); step();
    checks++; if (rom_addr !== 32'h80000000) begin fails++; $display("FAIL reset_pc got %h want %h", rom_addr, 32'h80000000); end
    checks++; if (if_id_instr !== 32'h0) begin fails++; $display("FAIL reset_instr got %h want 0", if_id_instr); end
    checks++; if (if_id_pc_plus4 !== 32'h0) begin fails++; $display("FAIL reset_pc4 got %h want 0", if_id_pc_plus4); end
    checks++; if (if_id_trap !== 1'b0 || if_id_epc !== 32'h0) begin fails++; $display("FAIL reset_trap got %b/%h want 0/0", if_id_trap, if_id_epc); end
    checks++; if (kernel !== 1'b1) begin fails++; $display("FAIL reset_kernel got %b want 1", kernel); end
    reset = 1'b1;
    step();
    checks++; if (if_id_instr !== 32'h08000003) begin fails++; $display("FAIL first_instr got %h want 08000003", if_id_instr); end
    checks++; if (if_id_pc_plus4 !== 32'h80000004) begin fails++; $display("FAIL first_pc4 got %h want 80000004", if_id_pc_plus4); end
    checks++; if (rom_addr !== 32'h80000004) begin fails++; $display("FAIL pc_seq1 got %h want 80000004", rom_addr); end
    step();
    checks++; if (rom_addr !== 32'h80000008) begin fails++; $display("FAIL pc_seq2 got %h want 80000008", rom_addr); end
    checks++; if (if_id_instr !== 32'h0004_7FFF) begin fails++; $display("FAIL second_instr got %h want 00047fff", if_id_instr); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFC;
    step();
    redirect_valid = 1'b0;
    checks++; if (rom_addr !== 32'hFFFFFFFC || if_id_instr !== 32'h0) begin fails++; $display("FAIL redirect_hi got %h/%h want fffffffc/0", rom_addr, if_id_instr); end
    step();
    checks++; if (rom_addr !== 32'h80000000 || kernel !== 1'b1) begin fails++; $display("FAIL wrap_kernel got %h/%b want 80000000/1", rom_addr, kernel); end
    checks++; if (if_id_pc_plus4 !== 32'h80000000 || if_id_instr !== 32'hFFFC_0000) begin fails++; $display("FAIL wrap_ifid got %h/%h want 80000000/fffc0000", if_id_pc_plus4, if_id_instr); end
    redirect_valid = 1'b1; redirect_pc = 32'h7FFFFFFC;
    step();
    redirect_valid = 1'b0;
    checks++; if (kernel !== 1'b0) begin fails++; $display("FAIL user_kernel got %b want 0", kernel); end
    step();
    checks++; if (rom_addr !== 32'h00000000 || kernel !== 1'b0) begin fails++; $display("FAIL wrap_user got %h/%b want 00000000/0", rom_addr, kernel); end
    checks++; if (if_id_pc_plus4 !== 32'h00000000) begin fails++; $display("FAIL wrap_user_pc4 got %h want 0", if_id_pc_plus4); end
  endtask

  task automatic test_stall_redirect();
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000010C;
    step();
    redirect_valid = 1'b0;
    checks++; if (rom_addr !== 32'h0000010C || if_id_instr !== 32'h0) begin fails++; $display("FAIL stall_redirect got %h/%h want 0000010c/0", rom_addr, if_id_instr); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (rom_addr !== 32'h0000010C || if_id_instr !== 32'h0 || if_id_trap !== 1'b0) begin fails++; $display("FAIL stall_hold got %h/%h/%b want 0000010c/0/0", rom_addr, if_id_instr, if_id_trap); end
    end
    stall = 1'b0;
    step();
    checks++; if (rom_addr !== 32'h00000110 || if_id_instr !== 32'h010C_FFFF || if_id_pc_plus4 !== 32'h00000110) begin fails++; $display("FAIL stall_release got %h/%h/%h want 00000110/010cffff/00000110", rom_addr, if_id_instr, if_id_pc_plus4); end
  endtask

  task automatic test_irq();
    redirect_valid = 1'b1; redirect_pc = 32'h00000120;
    step();
    redirect_valid = 1'b0; irq = 1'b1;
    checks++; if (rom_addr !== 32'h00000120) begin fails++; $display("FAIL irq_setup got %h want 00000120", rom_addr); end
    step();
    checks++; if (rom_addr !== 32'h80000004 || if_id_trap !== 1'b1 || if_id_epc !== 32'h00000120) begin fails++; $display("FAIL irq_take got %h/%b/%h want 80000004/1/00000120", rom_addr, if_id_trap, if_id_epc); end
    checks++; if (if_id_instr !== 32'h0) begin fails++; $display("FAIL irq_squash got %h want 0", if_id_instr); end
    step();
    checks++; if (rom_addr !== 32'h80000008 || if_id_trap !== 1'b0) begin fails++; $display("FAIL irq_pulse got %h/%b want 80000008/0", rom_addr, if_id_trap); end
    redirect_valid = 1'b1; redirect_pc = 32'h80000110; irq = 1'b0;
    step();
    redirect_valid = 1'b0; irq = 1'b1;
    step();
    checks++; if (rom_addr !== 32'h80000114 || if_id_trap !== 1'b0 || if_id_instr !== 32'h0110_7FFF) begin fails++; $display("FAIL irq_kernel got %h/%b/%h want 80000114/0/01107fff", rom_addr, if_id_trap, if_id_instr); end
    irq = 1'b0;
  endtask

  task automatic test_priority();
    redirect_valid = 1'b1; redirect_pc = 32'h00000200;
    step();
    irq = 1'b1; exc_req = 1'b1; redirect_pc = 32'h00000300;
    step();
    checks++; if (rom_addr !== 32'h80000008 || if_id_trap !== 1'b0 || if_id_instr !== 32'h0) begin fails++; $display("FAIL exc_wins got %h/%b/%h want 80000008/0/0", rom_addr, if_id_trap, if_id_instr); end
    exc_req = 1'b0;
    step();
    redirect_valid = 1'b0;
    checks++; if (rom_addr !== 32'h00000300 || if_id_trap !== 1'b0) begin fails++; $display("FAIL redirect_over_irq got %h/%b want 00000300/0", rom_addr, if_id_trap); end
    step();
    checks++; if (rom_addr !== 32'h80000004 || if_id_trap !== 1'b1 || if_id_epc !== 32'h00000300) begin fails++; $display("FAIL irq_retry got %h/%b/%h want 80000004/1/00000300", rom_addr, if_id_trap, if_id_epc); end
    stall = 1'b1;
    step();
    checks++; if (rom_addr !== 32'h80000004 || if_id_trap !== 1'b1) begin fails++; $display("FAIL trap_stall got %h/%b want 80000004/1", rom_addr, if_id_trap); end
    stall = 1'b0; irq = 1'b0;
    step();
    checks++; if (rom_addr !== 32'h80000008 || if_id_trap !== 1'b0) begin fails++; $display("FAIL trap_clear got %h/%b want 80000008/0", rom_addr, if_id_trap); end
  endtask

  task automatic test_align();
    redirect_valid = 1'b1; redirect_pc = 32'h00000102;
    step();
    redirect_valid = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
    checks++; if (rom_addr !== 32'h80000008 || if_misalign !== 1'b1 || if_id_instr !== 32'h0) begin fails++; $display("FAIL misalign got %h/%b/%h want 80000008/1/0", rom_addr, if_misalign, if_id_instr); end
    step();
    checks++; if (if_misalign !== 1'b0 || rom_addr !== 32'h8000000C) begin fails++; $display("FAIL misalign_pulse got %b/%h want 0/8000000c", if_misalign, rom_addr); end
`else
    checks++; if (rom_addr !== 32'h00000102 || kernel !== 1'b0) begin fails++; $display("FAIL unaligned_load got %h/%b want 00000102/0", rom_addr, kernel); end
    step();
    checks++; if (rom_addr !== 32'h00000106) begin fails++; $display("FAIL unaligned_next got %h want 00000106", rom_addr); end
`endif
  endtask

  task automatic test_async_reset();
    step(); step();
    #2;
    reset = 1'b0;
    #1;
    checks++; if (rom_addr !== 32'h80000000 || if_id_instr !== 32'h0 || if_id_trap !== 1'b0 || if_id_pc_plus4 !== 32'h0) begin fails++; $display("FAIL async_reset got %h/%h/%b/%h want 80000000/0/0/0", rom_addr, if_id_instr, if_id_trap, if_id_pc_plus4); end
    step();
    reset = 1'b1;
    step();
    checks++; if (if_id_instr !== 32'h08000003 || rom_addr !== 32'h80000004) begin fails++; $display("FAIL restart got %h/%h want 08000003/80000004", if_id_instr, rom_addr); end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_stall_redirect();
    test_irq();
    test_priority();
    test_align();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the pipelined MIPS core. Holds the PC, drives the combinational instruction ROM address, and captures the returned word into the IF/ID pipeline register. Selects the next PC from the reset, interrupt and exception vectors, the branch/jump redirect, stall hold, or PC+4. Squashes the fetched word on flush and tags an interrupt bubble with its return address so decode can write $k0.

Parameters:
RESET_VEC, 32'h80000000, PC after reset (kernel mode, ROM word 0).
IRQ_VEC, 32'h80000004, interrupt entry (ROM word 1).
EXC_VEC, 32'h80000008, exception entry (ROM word 2).
NOP_WORD, 32'h00000000, instruction injected on squash.

Ports:
clk  in  1  core clock, rising edge.
reset  in  1  asynchronous, active-low; 0 resets all state immediately.
rom_addr  out  32  current PC, driven combinationally from the PC register.
rom_data  in  32  ROM word for rom_addr, valid the same cycle.
stall  in  1  decode hazard; hold PC and IF/ID.
redirect_valid  in  1  taken branch/jump/jr resolved downstream.
redirect_pc  in  32  redirect target.
exc_req  in  1  downstream exception (illegal op); vector to EXC_VEC.
irq  in  1  level interrupt request from timer/UART.
kernel  out  1  PC[31]; 1 = kernel mode.
if_id_instr  out  32  registered instruction.
if_id_pc_plus4  out  32  registered PC+4 of if_id_instr.
if_id_trap  out  1  registered; 1 = bubble caused by a taken interrupt.
if_id_epc  out  32  registered return address, valid when if_id_trap=1.

Behaviour:
- Reset (reset=0, async): PC=RESET_VEC; if_id_instr=NOP_WORD; if_id_pc_plus4=0; if_id_trap=0; if_id_epc=0. Reset released mid-program restarts at RESET_VEC with an empty IF/ID.
- rom_addr = PC. IF/ID latency is one cycle: the word fetched at PC in cycle n appears on if_id_* in cycle n+1.
- PC+4 rule: {PC[31], PC[30:0]+4}. Bit 31 is sticky; the low 31 bits wrap modulo 2^31. Redirect and vectors load all 32 bits, so jr $k0 with bit31=0 leaves kernel mode.
- irq_take = irq & ~kernel & ~stall & ~redirect_valid & ~exc_req. A deferred irq is retried each cycle while irq is held.
- Priority per edge, highest first:
  1. exc_req: PC=EXC_VEC; IF/ID=NOP_WORD, trap=0. Overrides stall.
  2. redirect_valid: PC=redirect_pc; IF/ID=NOP_WORD, trap=0. Overrides stall.
  3. irq_take: PC=IRQ_VEC; IF/ID=NOP_WORD, trap=1, epc=PC. The squashed instruction is re-fetched on return.
  4. stall: PC and all if_id_* held.
  5. Otherwise: PC=PC+4; if_id_instr=rom_data; if_id_pc_plus4=PC+4; trap=0.
- if_id_trap is a one-cycle pulse unless the register is held by stall.
- No internal FSM beyond the PC/IF-ID registers. The state is the kernel bit, which gates irq.
- Simultaneous exc_req and redirect_valid: exc_req wins; the redirect is discarded.

Optional Feature:
IF_ALIGN_CHECK_EN. Defined: a redirect with redirect_pc[1:0]!=0 (and no exc_req) loads PC=EXC_VEC instead, squashes IF/ID, and pulses an extra output if_misalign (1 bit, registered, reset 0) for one cycle. Undefined: redirect_pc is loaded unchanged and the ROM ignores addr[1:0]; if_misalign does not exist.

Test Plan:
- Reset low then release -> rom_addr=0x80000000; next edge gives if_id_instr=0x08000003 and if_id_pc_plus4=0x80000004; following cycles give rom_addr 0x80000004, then 0x80000008.
- PC wrap: redirect to 0xFFFFFFFC then free-run -> next PC=0x80000000, kernel stays 1. Redirect to 0x7FFFFFFC -> next PC=0x00000000, kernel=0.
- redirect_valid with redirect_pc=0x0000010C while stall=1 -> if_id_instr=0, rom_addr=0x0000010C. Stall alone for 3 cycles -> rom_addr and if_id_* unchanged.
- irq=1 at PC=0x00000120, kernel=0 -> rom_addr=0x80000004, if_id_trap=1, if_id_epc=0x00000120. irq=1 while PC=0x80000110 -> ignored, PC increments.
- irq, redirect_valid and exc_req all asserted in one cycle -> PC=0x80000008, trap=0. Drop exc_req, keep irq -> irq taken one cycle later.
- IF_ALIGN_CHECK_EN: redirect_pc=0x00000102 -> PC=0x80000008, if_misalign pulses 1 for one cycle. Same stimulus without the macro -> PC=0x00000102.
